// File: rtl/ddr4_cmd_stats_window.sv
`default_nettype none
// ddr4_cmd_stats_window: per-bank open-row tracker with windowed DDR4 command statistics.
// Rev 1.0 - initial release.
module ddr4_cmd_stats_window #(
   parameter int WINDOW_CYCLES = 1024,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_act,
   input  logic             cmd_rd,
   input  logic             cmd_wr,
   input  logic             cmd_pre,
   input  logic             cmd_prea,
   input  logic             cmd_ref,
   input  logic [3:0]       bank,
   input  logic [16:0]      row,
   output logic [15:0]      open_mask,
   output logic             snap_valid,
   input  logic             snap_ready,
   output logic [CNT_W-1:0] snap_rd,
   output logic [CNT_W-1:0] snap_wr,
   output logic [CNT_W-1:0] snap_hit,
   output logic [CNT_W-1:0] snap_first,
   output logic [CNT_W-1:0] snap_act,
   output logic [CNT_W-1:0] snap_pre,
   output logic [CNT_W-1:0] snap_ref,
   output logic [CNT_W-1:0] snap_turn,
   output logic [CNT_W-1:0] snap_err,
   output logic [15:0]      snap_idx,
   output logic             snap_overrun
);

   localparam int CYC_W = $clog2(WINDOW_CYCLES);
   localparam int NCNT  = 9;
   localparam int C_RD = 0, C_WR = 1, C_HIT = 2, C_FIRST = 3, C_ACT = 4;
   localparam int C_PRE = 5, C_REF = 6, C_TURN = 7, C_ERR = 8;

   typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_RD = 2'd1, DIR_WR = 2'd2} dir_t;

   logic [CYC_W-1:0] cyc;
   logic [15:0]      acc_seen;
   logic [16:0]      open_row [16];
   dir_t             last_dir;
   logic [CNT_W-1:0] cnt      [NCNT];
   logic [CNT_W-1:0] snap     [NCNT];

   logic [15:0]      open_nxt;
   logic [15:0]      acc_nxt;
   dir_t             dir_nxt;
   logic [1:0]       inc      [NCNT];
   logic [CNT_W-1:0] cnt_nxt  [NCNT];
   logic [5:0]       cmds;
   logic             last_cyc;

   assign cmds     = {cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_prea, cmd_ref};
   assign last_cyc = (cyc == CYC_W'(WINDOW_CYCLES - 1));

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   // Only the highest-priority pulse is acted on; a collision still costs one error.
   always_comb begin
      inc      = '{default: 2'd0};
      open_nxt = open_mask;
      acc_nxt  = acc_seen;
      dir_nxt  = last_dir;
      if ($countones(cmds) > 1) inc[C_ERR] = 2'd1;
      if (cmd_act) begin
         inc[C_ACT] = 2'd1;
         if (open_mask[bank]) inc[C_ERR] = inc[C_ERR] + 2'd1;
         open_nxt[bank] = 1'b1;
         acc_nxt[bank]  = 1'b0;
      end else if (cmd_rd || cmd_wr) begin
         if (cmd_rd) inc[C_RD] = 2'd1;
         else        inc[C_WR] = 2'd1;
         if (open_mask[bank]) begin
            if (acc_seen[bank]) inc[C_HIT]   = 2'd1;
            else                inc[C_FIRST] = 2'd1;
            acc_nxt[bank] = 1'b1;
         end else begin
            inc[C_ERR] = inc[C_ERR] + 2'd1;
         end
         if ((cmd_rd && last_dir == DIR_WR) || (!cmd_rd && last_dir == DIR_RD))
            inc[C_TURN] = 2'd1;
         dir_nxt = cmd_rd ? DIR_RD : DIR_WR;
      end else if (cmd_pre) begin
         inc[C_PRE]     = 2'd1;
         open_nxt[bank] = 1'b0;
      end else if (cmd_prea) begin
         inc[C_PRE] = 2'd1;
         open_nxt   = '0;
      end else if (cmd_ref) begin
         inc[C_REF] = 2'd1;
         if (|open_mask) inc[C_ERR] = inc[C_ERR] + 2'd1;
      end
      for (int i = 0; i < NCNT; i++) cnt_nxt[i] = sat_add(cnt[i], inc[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc          <= '0;
         open_mask    <= '0;
         acc_seen     <= '0;
         last_dir     <= DIR_NONE;
         snap_valid   <= 1'b0;
         snap_idx     <= '0;
         snap_overrun <= 1'b0;
         for (int i = 0; i < 16; i++)   open_row[i] <= '0;
         for (int i = 0; i < NCNT; i++) begin
            cnt[i]  <= '0;
            snap[i] <= '0;
         end
      end else begin
         open_mask <= open_nxt;
         acc_seen  <= acc_nxt;
         last_dir  <= dir_nxt;
         if (cmd_act) open_row[bank] <= row;
         if (last_cyc) begin
            cyc        <= '0;
            snap_valid <= 1'b1;
            snap_idx   <= snap_idx + 16'd1;
            // Overwriting an unaccepted snapshot; a same-cycle accept is not an overrun.
            if (snap_valid && !snap_ready) snap_overrun <= 1'b1;
            for (int i = 0; i < NCNT; i++) begin
               snap[i] <= cnt_nxt[i];
               cnt[i]  <= '0;
            end
         end else begin
            cyc <= cyc + CYC_W'(1);
            if (snap_valid && snap_ready) snap_valid <= 1'b0;
            for (int i = 0; i < NCNT; i++) cnt[i] <= cnt_nxt[i];
         end
      end
   end

   assign snap_rd    = snap[C_RD];
   assign snap_wr    = snap[C_WR];
   assign snap_hit   = snap[C_HIT];
   assign snap_first = snap[C_FIRST];
   assign snap_act   = snap[C_ACT];
   assign snap_pre   = snap[C_PRE];
   assign snap_ref   = snap[C_REF];
   assign snap_turn  = snap[C_TURN];
   assign snap_err   = snap[C_ERR];

endmodule
`default_nettype wire

// File: doc/ddr4_cmd_stats_window.md
# ddr4_cmd_stats_window

Downstream stage of the DDR4 command decoder in the NoC/DDRMC performance-simulation bench. It consumes the decoder's single-cycle command pulses plus bank/row, tracks per-bank open-row state, and classifies every read/write as page-hit or first-access after activate. It also counts rd/wr turnarounds and protocol violations, and emits a fixed-length windowed statistics snapshot over a valid/ready handshake.

## Interface
- WINDOW_CYCLES, 1024: window length in clk cycles, ≥2
- CNT_W, 16: width of every statistics counter
- clk  in  1  command clock (same edge the decoder pulses are valid on)
- rst_n  in  1  asynchronous active-low reset
- cmd_act / cmd_rd / cmd_wr / cmd_pre / cmd_prea / cmd_ref  in  1 each  decoded command pulses, one cycle wide
- bank  in  4  {ba,bg}, valid with any cmd_* pulse
- row  in  17  row address, valid with cmd_act
- open_mask  out  16  live per-bank open flag
- snap_valid  out  1  snapshot available
- snap_ready  in  1  consumer accepts snapshot
- snap_rd, snap_wr, snap_hit, snap_first, snap_act, snap_pre, snap_ref, snap_turn, snap_err  out  CNT_W each  window totals
- snap_idx  out  16  window sequence number, wraps at 2^16
- snap_overrun  out  1  sticky: a snapshot was overwritten before acceptance

## Operation
- Per-bank state: open bit, open_row[16:0], acc_seen bit (≥1 rd/wr since ACT).
- Multiple cmd_* high in one cycle: only the highest-priority command is processed (act > rd > wr > pre > prea > ref); err +1.
- cmd_act: bank closed → open=1, open_row=row, acc_seen=0, act +1. Bank already open → err +1, act +1, row overwritten, acc_seen=0.
- cmd_rd / cmd_wr: bank open → rd/wr +1. acc_seen=1 → hit +1, else first +1. Then set acc_seen=1. Bank closed → rd/wr +1, err +1, no hit/first.
- Turnaround: last_dir register (none/rd/wr, reset none). A rd when last_dir=wr, or a wr when last_dir=rd → turn +1. last_dir updates on every rd/wr. last_dir persists across windows.
- cmd_pre: open[bank]=0, pre +1. Precharging a closed bank is legal, with no err.
- cmd_prea: all open bits cleared, pre +1.
- cmd_ref: ref +1. Any bank open → err +1.
- All counters saturate at 2^CNT_W−1; they do not wrap.
- Window: cyc counter runs 0..WINDOW_CYCLES−1. On the edge where cyc==WINDOW_CYCLES−1:
  - snapshot regs load the counter values including that cycle's command;
  - live counters clear to 0;
  - snap_idx increments;
  - snap_valid=1.
- Handshake: snap_valid stays high, with snap_* stable, until a cycle with snap_valid&&snap_ready; snap_valid drops on the next edge.
- Simultaneous accept and new snapshot in the same cycle: new data loads, snap_valid stays 1, no overrun.
- New snapshot while snap_valid&&!snap_ready: data overwritten, snap_overrun=1 (cleared only by reset).
- Bank state (open_mask, rows, acc_seen) is not cleared at window boundaries.

## Timing
- Reset values: open_mask=0, snap_valid=0, all snap_* =0, snap_idx=0, snap_overrun=0, cyc=0, last_dir=none, all counters 0.
- Reset may assert at any time, including mid-window or with snap_valid pending. All state clears immediately and the partial window is discarded.
- Command on edge N: open_mask reflects it after edge N. Counters include it after edge N.
- First snap_valid rises after edge WINDOW_CYCLES (counting from the first edge after reset release). Subsequent snapshots follow every WINDOW_CYCLES edges.
- One command accepted per cycle; no back-pressure on the command side.

## Test plan
- WINDOW_CYCLES=16, snap_ready=1: ACT b3 row 0x1A5, then RD b3 ×3, WR b3 ×1 → snap_act=1, rd=3, wr=1, first=1, hit=3, turn=1, err=0, snap_idx=1.
- RD b5 with no prior ACT, then REF while b3 open → snap_err=2, snap_rd=1, hit=0, first=0.
- ACT b0, b1, b2; PREA; ACT b0 → open_mask 0x0007 → 0x0000 → 0x0001; snap_pre=1, act=4, err=0.
- snap_ready=0 for 40 cycles with WINDOW_CYCLES=16 → snap_valid stays high, snap_overrun=1 after the second boundary, snap_idx=2 displayed; assert ready → snap_valid falls next edge.
- CNT_W=4: 20 RDs in one window of 32 cycles → snap_rd=15 (saturated).
- Assert rst_n=0 mid-window with snap_valid=1 and banks open → all outputs 0 asynchronously; after release, first snapshot arrives WINDOW_CYCLES edges later with snap_idx=1.
